// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants, framebuffer geometry, pixel type and
// scanline-fetch FSM states for the 640x480 VGA scanout path.
package vga_pkg;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned H_TOTAL   = 800;
  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned V_TOTAL   = 525;

  localparam int unsigned FB_W     = 160;
  localparam int unsigned FB_H     = 120;
  localparam int unsigned SCALE    = 4;
  localparam int unsigned FB_WORDS = FB_W * FB_H;

  typedef logic [7:0] pixel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/line_buffer_pp.sv
// line_buffer_pp: ping-pong pair of FB_W x 8-bit scanline buffers.
//   clk             write clock
//   wr_en/wr_sel    write strobe and buffer select (0/1)
//   wr_idx/wr_data  column and pixel written
//   rd_sel/rd_idx   buffer select and column for the combinational read
//   rd_data         pixel at rd_idx of buffer rd_sel
// Contents are not reset.
module line_buffer_pp
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_idx,
  input  pixel_t     wr_data,
  input  logic       rd_sel,
  input  logic [7:0] rd_idx,
  output pixel_t     rd_data
);

  pixel_t buf0 [FB_W];
  pixel_t buf1 [FB_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_sel) begin
        buf1[wr_idx] <= wr_data;
      end else begin
        buf0[wr_idx] <= wr_data;
      end
    end
  end

  assign rd_data = rd_sel ? buf1[rd_idx] : buf0[rd_idx];

endmodule

// File: rtl/fb_scanout_arbiter.sv
// fb_scanout_arbiter: shares a single-port 160x120x8 framebuffer RAM between
// scanline prefetch (into a ping-pong line buffer) and host pixel writes,
// and produces the 4x-upscaled display pixel.
//   clk, reset            pixel clock, async active-low reset
//   hcount/vcount         raster position; active_video visible-region flag
//   wr_valid/addr/data    host write request; wr_ready accepted this cycle
//   ram_*                 framebuffer RAM port (ram_rdata one cycle after ram_re)
//   pixel                 registered display pixel
//   underrun/_clr         sticky late-fetch flag and its clear
module fb_scanout_arbiter
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        active_video,
  input  logic        wr_valid,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic [14:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic        ram_re,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  pixel,
  output logic        underrun,
  input  logic        underrun_clr
);

  fetch_state_e state_q, state_d;
  logic [7:0]   col_q, col_d;
  logic [6:0]   row_q, row_d;
  logic         rr_q, rr_d;          // 1: host wins the next contended cycle
  logic         active_q, active_d;  // buffer being displayed
  logic         rd_pend_q, rd_pend_d;
  logic [7:0]   rd_col_q, rd_col_d;
  pixel_t       pixel_q, pixel_d;
  logic         underrun_q, underrun_d;

  logic         trigger, swap;
  logic         fetch_req, host_req, contend, wr_in_range;
  logic         grant_fetch, grant_host;
  logic [14:0]  fetch_addr;
  logic [8:0]   pix_col;
  logic [7:0]   pix_idx;
  pixel_t       lb_rd;

  assign trigger = (hcount == 11'd0) &&
                   (((vcount[1:0] == 2'd2) && (vcount < 10'(V_DISPLAY - 2))) ||
                    (vcount == 10'(V_TOTAL - 5)));
  assign swap    = (hcount == 11'(H_TOTAL - 1)) &&
                   (((vcount[1:0] == 2'd3) && (vcount < 10'(V_DISPLAY - 1))) ||
                    (vcount == 10'(V_TOTAL - 1)));

  // Out-of-range host writes never touch the RAM, so they are accepted
  // immediately and take no part in arbitration.
  assign wr_in_range = (wr_addr < 15'(FB_WORDS));
  assign host_req    = wr_valid && wr_in_range;
  // No new read on the swap cycle: the fetch is being abandoned anyway.
  assign fetch_req   = (state_q == FETCH) && (col_q < 8'(FB_W)) && !swap;
  assign contend     = fetch_req && host_req;
  assign grant_fetch = fetch_req && !(contend && rr_q);
  assign grant_host  = host_req && !(contend && !rr_q);

  assign fetch_addr = 15'(row_q) * 15'(FB_W) + 15'(col_q);

  assign wr_ready  = grant_host || (wr_valid && !wr_in_range);
  assign ram_we    = grant_host;
  assign ram_re    = grant_fetch;
  assign ram_addr  = grant_fetch ? fetch_addr : wr_addr;
  assign ram_wdata = wr_data;

  assign pix_col = 9'(hcount >> $clog2(SCALE));
  assign pix_idx = (pix_col < 9'(FB_W)) ? pix_col[7:0] : '0;

  line_buffer_pp u_line_buffer_pp (
    .clk     (clk),
    .wr_en   (rd_pend_q),
    .wr_sel  (~active_q),
    .wr_idx  (rd_col_q),
    .wr_data (ram_rdata),
    .rd_sel  (active_q),
    .rd_idx  (pix_idx),
    .rd_data (lb_rd)
  );

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    rr_d       = rr_q;
    active_d   = active_q;
    rd_pend_d  = grant_fetch;
    rd_col_d   = col_q;
    underrun_d = underrun_q;
    pixel_d    = active_video ? lb_rd : '0;

    if (grant_fetch) begin
      col_d = col_q + 8'd1;
    end
    if (contend) begin
      rr_d = ~rr_q;
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = FETCH;
          col_d   = '0;
          rr_d    = 1'b0;
          row_d   = (vcount == 10'(V_TOTAL - 5)) ? '0
                  : 7'(vcount >> $clog2(SCALE)) + 7'd1;
        end
      end
      FETCH: begin
        if (rd_pend_q && (rd_col_q == 8'(FB_W - 1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (underrun_clr) begin
      underrun_d = 1'b0;
    end
    // Swap always happens; a fetch still running at that point is late.
    if (swap) begin
      active_d = ~active_q;
      if (state_q == FETCH) begin
        underrun_d = 1'b1;
        state_d    = IDLE;
        rd_pend_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      rr_q       <= 1'b0;
      active_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_col_q   <= '0;
      pixel_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rr_q       <= rr_d;
      active_q   <= active_d;
      rd_pend_q  <= rd_pend_d;
      rd_col_q   <= rd_col_d;
      pixel_q    <= pixel_d;
      underrun_q <= underrun_d;
    end
  end

  assign pixel    = pixel_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Testbench for fb_scanout_arbiter: behavioural framebuffer RAM, directed
// vector table for the idle write path, hand sequences for fetch, contention,
// underrun, reset abort and frame wrap.
module tb_fb_scanout_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        active_video = 1'b0;
  logic        wr_valid = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [7:0]  ram_rdata;
  logic [7:0]  pixel;
  logic        underrun;
  logic        underrun_clr = 1'b0;

  always #5 clk = ~clk;

  fb_scanout_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .hcount       (hcount),
    .vcount       (vcount),
    .active_video (active_video),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_re       (ram_re),
    .ram_rdata    (ram_rdata),
    .pixel        (pixel),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  // Framebuffer RAM model: write on ram_we, read data one cycle after ram_re.
  logic [7:0] mem [19200];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  int re_cnt = 0;
  int both_cnt = 0;
  always @(negedge clk) begin
    if (ram_re) re_cnt++;
    if (ram_re && ram_we) both_cnt++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_pos(input int h, input int v);
    hcount       = 11'(h);
    vcount       = 10'(v);
    active_video = (h < 640) && (v < 480);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      set_pos(h, v);
      tick();
    end
  endtask

  task automatic hw(input int a, input int d);
    wr_valid = 1'b1;
    wr_addr  = 15'(a);
    wr_data  = 8'(d);
    set_pos(5, 100);
    tick();
    wr_valid = 1'b0;
  endtask

  typedef struct {
    logic        wv;
    logic [14:0] wa;
    logic [7:0]  wd;
    logic        e_rdy;
    logic        e_we;
    logic        e_re;
    logic        chk_addr;
    logic [14:0] e_addr;
    string       name;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int re0;
    int alt_err;
    int last_re;

    vecs[0] = '{1'b1, 15'd0,     8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 15'd0,     "wr_addr0"};
    vecs[1] = '{1'b1, 15'd19199, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 15'd19199, "wr_last"};
    vecs[2] = '{1'b1, 15'd19200, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0,     "wr_oob_19200"};
    vecs[3] = '{1'b1, 15'd32767, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0,     "wr_oob_max"};
    vecs[4] = '{1'b0, 15'd160,   8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 15'd0,     "no_req"};
    vecs[5] = '{1'b1, 15'd160,   8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 15'd160,   "wr_row1"};

    // Reset state
    set_pos(5, 100);
    tick(); tick(); tick();
    chk("rst_pixel", pixel, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ram_re", ram_re, 0);
    chk("rst_ram_we", ram_we, 0);
    reset = 1'b1;
    tick();

    // Idle write path
    foreach (vecs[i]) begin
      wr_valid = vecs[i].wv;
      wr_addr  = vecs[i].wa;
      wr_data  = vecs[i].wd;
      set_pos(5, 100);
      chk({vecs[i].name, "_rdy"}, wr_ready, vecs[i].e_rdy);
      chk({vecs[i].name, "_we"}, ram_we, vecs[i].e_we);
      chk({vecs[i].name, "_re"}, ram_re, vecs[i].e_re);
      if (vecs[i].chk_addr) chk({vecs[i].name, "_addr"}, ram_addr, vecs[i].e_addr);
      tick();
    end
    wr_valid = 1'b0;

    // Preload rows 0..2 through the host port
    for (int c = 0; c < 160; c++) begin
      hw(c, c ^ 8'h5A);
      hw(160 + c, c);
      hw(320 + c, 255 - c);
    end

    // Prefetch of row 1 at vcount=2, display at vcount=4
    re0 = re_cnt;
    set_pos(0, 2);
    chk("trig_cycle_re", ram_re, 0);
    tick();
    for (int h = 1; h < 800; h++) begin
      set_pos(h, 2);
      if (h == 1) begin
        chk("fetch_first_re", ram_re, 1);
        chk("fetch_first_addr", ram_addr, 160);
      end
      if (h == 160) begin
        chk("fetch_last_re", ram_re, 1);
        chk("fetch_last_addr", ram_addr, 319);
      end
      if (h == 161) chk("fetch_after_re", ram_re, 0);
      tick();
    end
    chk("fetch_re_count", re_cnt - re0, 160);
    run(3, 0, 799);
    for (int h = 0; h <= 40; h++) begin
      set_pos(h, 4);
      tick();
      if (h == 8) chk("pix_v4_h8", pixel, 2);
      if (h == 20) chk("pix_v4_h20", pixel, 5);
    end
    set_pos(700, 4);
    tick();
    chk("pix_blank", pixel, 0);

    // Fully contended fetch of row 2 at vcount=6
    re0 = re_cnt;
    alt_err = 0;
    last_re = -1;
    for (int h = 0; h < 800; h++) begin
      wr_valid = 1'b1;
      wr_addr  = 15'(10000 + h);
      wr_data  = 8'(h);
      set_pos(h, 6);
      if (h == 0) chk("cont_idle_grant", wr_ready, 1);
      if (h >= 1 && h <= 319) begin
        if (ram_re != 1'(h % 2) || wr_ready != 1'((h + 1) % 2)) alt_err++;
      end
      if (h == 320) chk("cont_host_after", wr_ready, 1);
      if (ram_re) last_re = h;
      tick();
    end
    wr_valid = 1'b0;
    chk("cont_alternation_errs", alt_err, 0);
    chk("cont_re_count", re_cnt - re0, 160);
    chk("cont_last_re_h", last_re, 319);
    chk("cont_host_wr_h2", mem[10002], 2);
    chk("cont_host_wr_h400", mem[10400], 144);
    run(7, 0, 799);
    chk("cont_no_underrun", underrun, 0);
    for (int h = 0; h < 640; h++) begin
      set_pos(h, 8);
      tick();
      if (h == 4) chk("pix_v8_h4", pixel, 254);
      if (h == 636) chk("pix_v8_h636", pixel, 96);
    end

    // Underrun: swap point reached while still fetching
    run(10, 0, 10);
    set_pos(799, 11);
    tick();
    chk("underrun_set", underrun, 1);
    set_pos(0, 12);
    chk("underrun_abort_re", ram_re, 0);
    tick();
    run(12, 1, 5);
    chk("underrun_sticky", underrun, 1);
    underrun_clr = 1'b1;
    set_pos(6, 12);
    tick();
    underrun_clr = 1'b0;
    chk("underrun_cleared", underrun, 0);
    run(14, 0, 5);
    underrun_clr = 1'b1;
    set_pos(799, 15);
    tick();
    underrun_clr = 1'b0;
    chk("underrun_set_wins", underrun, 1);
    underrun_clr = 1'b1;
    set_pos(0, 16);
    tick();
    underrun_clr = 1'b0;
    chk("underrun_cleared2", underrun, 0);

    // Reset during a fetch
    run(2, 0, 49);
    set_pos(50, 2);
    chk("pre_reset_re", ram_re, 1);
    reset = 1'b0;
    #1;
    chk("reset_async_pixel", pixel, 0);
    tick();
    chk("reset_re", ram_re, 0);
    chk("reset_pixel", pixel, 0);
    set_pos(10, 519);
    tick();
    reset = 1'b1;
    re0 = re_cnt;
    run(519, 11, 20);
    chk("post_reset_no_access", re_cnt - re0, 0);
    for (int h = 0; h < 800; h++) begin
      set_pos(h, 520);
      if (h == 1) begin
        chk("row0_first_re", ram_re, 1);
        chk("row0_first_addr", ram_addr, 0);
      end
      if (h == 2) chk("row0_second_addr", ram_addr, 1);
      tick();
    end

    // Frame wrap
    set_pos(799, 524);
    tick();
    chk("wrap_no_underrun", underrun, 0);
    for (int h = 0; h < 640; h++) begin
      set_pos(h, 0);
      tick();
      if (h == 0) chk("wrap_pix_h0", pixel, 8'h5A);
      if (h == 100) chk("wrap_pix_h100", pixel, 25 ^ 8'h5A);
      if (h == 637) chk("wrap_pix_h637", pixel, 159 ^ 8'h5A);
    end

    chk("we_re_exclusive", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_scanout_arbiter.md
FB_SCANOUT_ARBITER -- requirements
Module: fb_scanout_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  pixel clock (25.175 MHz); reset  input  1  asynchronous, active-low.
REQ-002 SHALL have ports: hcount  input  11  horizontal position 0-799; vcount  input  10  vertical position 0-524; active_video  input  1  visible-region flag.
REQ-003 SHALL have ports: wr_valid  input  1  host write request; wr_addr  input  15  framebuffer word address; wr_data  input  8  pixel; wr_ready  output  1  write accepted this cycle.
REQ-004 SHALL have ports: ram_addr  output  15; ram_wdata  output  8; ram_we  output  1; ram_re  output  1; ram_rdata  input  8, valid exactly 1 cycle after ram_re.
REQ-005 SHALL have ports: pixel  output  8  registered display pixel; underrun  output  1  sticky fetch-late flag; underrun_clr  input  1  clears underrun.

Function
REQ-006 SHALL share one single-port framebuffer RAM (160x120, 8 bpp, row-major, address = row*160+col) between scanline prefetch and host writes.
REQ-007 SHALL hold two 160-entry line buffers (ping-pong): display reads the active buffer while prefetch fills the other.
REQ-008 SHALL start a prefetch at hcount==0 when vcount[1:0]==2 and vcount<478, target row (vcount>>2)+1; and at hcount==0 when vcount==520, target row 0.
REQ-009 SHALL swap buffers at hcount==799 when (vcount[1:0]==3 and vcount<479) or vcount==524.
REQ-010 FSM states: IDLE, FETCH. IDLE->FETCH on trigger (REQ-008), column counter cleared; FETCH->IDLE when read data for column 159 is written into the line buffer.
REQ-011 In IDLE, SHALL grant every wr_valid (wr_ready=1 combinationally, ram_we=1, ram_addr=wr_addr, same cycle).
REQ-012 In FETCH, SHALL arbitrate round-robin per cycle between fetch and host: when both request, grant alternates starting with fetch; a lone requester is always granted.
REQ-013 Fetch issue: ram_re=1, ram_addr=row*160+col, col increments per granted read; returned ram_rdata written to fill buffer at col issued one cycle earlier.
REQ-014 Host writes with wr_addr>=19200 SHALL be accepted (wr_ready=1) and discarded (ram_we=0).
REQ-015 ram_we and ram_re SHALL never be high in the same cycle.
REQ-016 pixel SHALL equal active_buffer[hcount>>2] registered one cycle later when active_video was 1 that cycle; 8'h00 otherwise.
REQ-017 If a swap point (REQ-009) occurs while state==FETCH, SHALL set underrun, swap anyway, abort fetch to IDLE.
REQ-018 underrun_clr SHALL clear underrun unless a new underrun occurs the same cycle (set wins).
REQ-019 Trigger while already in FETCH SHALL be ignored (cannot occur under legal timing).
REQ-020 Worst-case fetch (fully contended) SHALL complete in 321 cycles, well inside the 1600-cycle window.

Reset
REQ-021 On reset low: state=IDLE, col=0, active buffer=0, pixel=0, underrun=0, ram_re=0, ram_we=0, wr_ready follows IDLE rule after release; line buffer contents undefined.
REQ-022 Reset asserted mid-FETCH SHALL abort the fetch; no RAM access until a new trigger.

Structure
REQ-023 Shared package vga_pkg SHALL hold H_DISPLAY/H_TOTAL/V_DISPLAY/V_TOTAL, FB_W=160, FB_H=120, SCALE=4, FB_WORDS=19200, pixel_t (8-bit), fetch state enum.
REQ-024 Sub-module line_buffer_pp: two 160x8 synchronous-write, combinational-read arrays with select input; arbitration and FSM stay in fb_scanout_arbiter.

Verification
REQ-025 Preload RAM row 1 with col value; run vcount 2->4 -> ram_re asserted 160 cycles from (vcount=2,hcount=0), pixel at vcount=4 hcount=8 (sampled one cycle later) = 2.
REQ-026 wr_valid held high throughout FETCH -> grants alternate fetch/host, fetch done by cycle 321, no underrun, ram_we&ram_re never both 1.
REQ-027 Host write addr 19200, data 8'hAA, in IDLE -> wr_ready=1, ram_we=0.
REQ-028 Force ram_re stall (hold FSM via reset of counter model) so fetch incomplete at vcount=3 hcount=799 -> underrun=1 next cycle; underrun_clr pulse -> 0.
REQ-029 Assert reset at vcount=2 hcount=50 -> pixel=0, ram_re=0 next cycle, state IDLE; after release at vcount=520 hcount=0 fetch of row 0 begins.
REQ-030 Frame wrap: vcount 524 hcount 799 -> buffer swap; vcount=0 first visible pixels show row 0 data.
